// File: rtl/aes_sub_bytes_serial.sv
// Serial AES SubBytes/InvSubBytes unit: one 128-bit state is substituted in place,
// NUM_SBOX bytes per cycle, between a valid/ready input and a valid/ready output.

module aes_sbox (
    input  logic       op_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ (x & {8{b[i]}});
            x   = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] aff_fwd(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] aff_inv(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    logic [7:0] inv_in_s;
    logic [7:0] inv_out_s;

    // one shared inversion; the affine map sits before it for the inverse direction
    always_comb begin
        inv_in_s  = 8'h00;
        inv_out_s = 8'h00;
        data_o    = 8'h00;
        if (op_i) begin
            inv_in_s  = aff_inv(data_i);
            inv_out_s = gf_inv(inv_in_s);
            data_o    = inv_out_s;
        end else begin
            inv_in_s  = data_i;
            inv_out_s = gf_inv(inv_in_s);
            data_o    = aff_fwd(inv_out_s);
        end
    end

endmodule

module aes_sub_bytes_serial #(
    parameter int NUM_SBOX = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic         op_i,
    input  logic [127:0] data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] data_o,
    output logic         busy_o
);

    localparam int NUM_CHUNKS = 16 / NUM_SBOX;
    localparam int CHUNK_W    = 8 * NUM_SBOX;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 ||
          NUM_SBOX == 8 || NUM_SBOX == 16)) begin : g_bad_num_sbox
        $error("aes_sub_bytes_serial: NUM_SBOX must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                               state_r;
    logic [CNT_W-1:0]                     cnt_r;
    logic                                 op_r;
    logic [NUM_CHUNKS-1:0][CHUNK_W-1:0]   buf_r;
    logic [NUM_CHUNKS-1:0][CHUNK_W-1:0]   buf_next_s;
    logic [CHUNK_W-1:0]                   cur_chunk_s;
    logic [CHUNK_W-1:0]                   sub_chunk_s;
    logic                                 in_ready_r;
    logic                                 out_valid_r;
    logic                                 busy_r;

    for (genvar i = 0; i < NUM_SBOX; i++) begin : g_sbox
        aes_sbox u_sbox (
            .op_i   (op_r),
            .data_i (cur_chunk_s[8*i +: 8]),
            .data_o (sub_chunk_s[8*i +: 8])
        );
    end

    // select the current chunk and merge its substituted bytes back into the state
    always_comb begin
        cur_chunk_s       = buf_r[cnt_r];
        buf_next_s        = buf_r;
        buf_next_s[cnt_r] = sub_chunk_s;
    end

    // control FSM, state buffer and registered handshake/status outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            op_r        <= 1'b0;
            buf_r       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else if (clear_i) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            op_r        <= 1'b0;
            buf_r       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        buf_r      <= data_i;
                        op_r       <= op_i;
                        cnt_r      <= '0;
                        state_r    <= ST_BUSY;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    buf_r <= buf_next_s;
                    if (cnt_r == LAST_CHUNK) begin
                        cnt_r       <= '0;
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= '0;
                    op_r        <= 1'b0;
                    buf_r       <= '0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_r;
    assign out_valid_o = out_valid_r;
    assign busy_o      = busy_r;
    assign data_o      = buf_r;

endmodule

// File: tb/tb_aes_sub_bytes_serial.sv
// Bench for aes_sub_bytes_serial: three instances (4, 1 and 16 S-boxes) share stimulus
// and are compared against a table-driven S-box model built from GF(2^8) arithmetic.

module tb_aes_sub_bytes_serial;

    localparam int NS [3] = '{4, 1, 16};

    logic         clk;
    logic         rst_n;
    logic         clear;
    logic         in_valid;
    logic         op;
    logic [127:0] din;
    logic         out_ready;
    logic         in_ready  [3];
    logic         out_valid [3];
    logic         busy      [3];
    logic [127:0] dout      [3];

    logic [7:0] fwd_tab [0:255];
    logic [7:0] inv_tab [0:255];

    int total = 0;
    int bad   = 0;

    aes_sub_bytes_serial #(.NUM_SBOX(4)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .in_valid_i(in_valid),
        .in_ready_o(in_ready[0]), .op_i(op), .data_i(din), .out_valid_o(out_valid[0]),
        .out_ready_i(out_ready), .data_o(dout[0]), .busy_o(busy[0]));

    aes_sub_bytes_serial #(.NUM_SBOX(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .in_valid_i(in_valid),
        .in_ready_o(in_ready[1]), .op_i(op), .data_i(din), .out_valid_o(out_valid[1]),
        .out_ready_i(out_ready), .data_o(dout[1]), .busy_o(busy[1]));

    aes_sub_bytes_serial #(.NUM_SBOX(16)) u_dut16 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .in_valid_i(in_valid),
        .in_ready_o(in_ready[2]), .op_i(op), .data_i(din), .out_valid_o(out_valid[2]),
        .out_ready_i(out_ready), .data_o(dout[2]), .busy_o(busy[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // polynomial product followed by reduction modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul_ref(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        logic [15:0] poly;
        p    = 16'h0000;
        poly = 16'h011b;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ ({8'h00, a} << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (poly << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] affine_ref(input logic [7:0] x);
        logic [7:0] c;
        logic [7:0] y;
        c = 8'h63;
        for (int i = 0; i < 8; i++)
            y[i] = x[i] ^ x[(i+4)%8] ^ x[(i+5)%8] ^ x[(i+6)%8] ^ x[(i+7)%8] ^ c[i];
        return y;
    endfunction

    function automatic logic [127:0] ref_sub(input logic [127:0] d, input logic opv);
        logic [127:0] r;
        for (int k = 0; k < 16; k++)
            r[8*k +: 8] = opv ? inv_tab[d[8*k +: 8]] : fwd_tab[d[8*k +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (!(in_ready[0] && in_ready[1] && in_ready[2]) && n < 50) begin
            tick();
            n++;
        end
        check_eq("idle_wait", {127'd0, in_ready[0] & in_ready[1] & in_ready[2]}, 128'd1);
    endtask

    // one transaction with out_ready high; op/data wiggle while the state is in flight
    task automatic run_state(input logic [127:0] d, input logic opv, input logic [127:0] exp);
        wait_idle();
        clear     = 1'b0;
        out_ready = 1'b1;
        din       = d;
        op        = opv;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++)
            check_eq($sformatf("busy_ns%0d", NS[i]), {127'd0, busy[i]}, 128'd1);
        for (int k = 1; k <= 16; k++) begin
            op  = 1'($urandom_range(0, 1));
            din = rand128();
            tick();
            for (int i = 0; i < 3; i++) begin
                check_eq($sformatf("valid_ns%0d_k%0d", NS[i], k), {127'd0, out_valid[i]},
                         {127'd0, k == 16 / NS[i]});
                if (k == 16 / NS[i])
                    check_eq($sformatf("data_ns%0d", NS[i]), dout[i], exp);
            end
        end
        tick();
        for (int i = 0; i < 3; i++)
            check_eq($sformatf("ready_after_ns%0d", NS[i]), {127'd0, in_ready[i]}, 128'd1);
    endtask

    initial begin
        logic [127:0] d;
        logic [127:0] e;
        logic [7:0]   inv;
        logic         o;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul_ref(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            fwd_tab[x] = affine_ref(inv);
        end
        for (int x = 0; x < 256; x++)
            inv_tab[fwd_tab[x]] = 8'(x);

        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        op        = 1'b0;
        din       = 128'd0;
        out_ready = 1'b1;
        #12;
        for (int i = 0; i < 3; i++) begin
            check_eq("rst_in_ready", {127'd0, in_ready[i]}, 128'd1);
            check_eq("rst_out_valid", {127'd0, out_valid[i]}, 128'd0);
            check_eq("rst_busy", {127'd0, busy[i]}, 128'd0);
            check_eq("rst_data", dout[i], 128'd0);
        end
        rst_n = 1'b1;
        tick();

        run_state(128'h00112233445566778899aabbccddeeff, 1'b0,
                  128'h638293c31bfc33f5c4eeacea4bc12816);
        run_state(128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1,
                  128'h00112233445566778899aabbccddeeff);
        run_state({16{8'h63}}, 1'b1, {16{8'h00}});
        run_state({16{8'h53}}, 1'b0, {16{8'hed}});

        for (int t = 0; t < 12; t++) begin
            d = rand128();
            o = 1'($urandom_range(0, 1));
            run_state(d, o, ref_sub(d, o));
        end
        d = rand128();
        run_state(ref_sub(d, 1'b0), 1'b1, d);

        // result held in DONE while the consumer stalls; new input is ignored
        wait_idle();
        d         = rand128();
        e         = ref_sub(d, 1'b0);
        out_ready = 1'b0;
        din       = d;
        op        = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (16) tick();
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            din      = rand128();
            op       = 1'($urandom_range(0, 1));
            tick();
            for (int i = 0; i < 3; i++) begin
                check_eq($sformatf("hold_data_ns%0d", NS[i]), dout[i], e);
                check_eq($sformatf("hold_valid_ns%0d", NS[i]), {127'd0, out_valid[i]}, 128'd1);
                check_eq($sformatf("hold_ready_ns%0d", NS[i]), {127'd0, in_ready[i]}, 128'd0);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            check_eq("release_ready", {127'd0, in_ready[i]}, 128'd1);
            check_eq("release_valid", {127'd0, out_valid[i]}, 128'd0);
            check_eq("release_data", dout[i], e);
        end

        // clear at cnt=2 of the four-S-box instance discards the state in flight
        wait_idle();
        din      = rand128();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("clr_ready", {127'd0, in_ready[i]}, 128'd1);
            check_eq("clr_busy", {127'd0, busy[i]}, 128'd0);
            check_eq("clr_data", dout[i], 128'd0);
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            check_eq("clr_no_valid", {127'd0, out_valid[0] | out_valid[1] | out_valid[2]},
                     128'd0);
        end
        d = rand128();
        run_state(d, 1'b0, ref_sub(d, 1'b0));

        // clear beats a simultaneous acceptance
        in_valid = 1'b1;
        clear    = 1'b1;
        din      = rand128();
        tick();
        in_valid = 1'b0;
        clear    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("clr_acc_busy", {127'd0, busy[i]}, 128'd0);
            check_eq("clr_acc_data", dout[i], 128'd0);
        end

        // asynchronous reset in the middle of BUSY
        din      = rand128();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("arst_ready", {127'd0, in_ready[i]}, 128'd1);
            check_eq("arst_valid", {127'd0, out_valid[i]}, 128'd0);
            check_eq("arst_busy", {127'd0, busy[i]}, 128'd0);
            check_eq("arst_data", dout[i], 128'd0);
        end
        #2;
        rst_n = 1'b1;
        tick();
        d = rand128();
        run_state(d, 1'b1, ref_sub(d, 1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
